// File: rtl/clk_step_pkg.sv
// Shared types and constants for the front-panel step controller.
package clk_step_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } deb_state_t;

  localparam logic SEL_MANUAL = 1'b0;
  localparam logic SEL_SLOW   = 1'b1;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the manual button; man_evt is a one-cycle registered pulse
// DEBOUNCE_CYCLES stable samples after the synchronized rise; no backpressure, force_en realigns state.
module btn_debounce
  import clk_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic force_en,
  input  logic force_level,
  output logic man_evt,
  output logic sync_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  deb_state_t            state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  evt_nx;

  assign sync_level = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state   <= LOW;
      cnt     <= '0;
      man_evt <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], din};
      state   <= state_nx;
      cnt     <= cnt_nx;
      man_evt <= evt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    evt_nx   = 1'b0;
    if (force_en) begin
      // Realign silently to the level already present so a source switch never fires a step.
      state_nx = force_level ? HIGH : LOW;
      cnt_nx   = '0;
    end else begin
      case (state)
        LOW: begin
          if (sync_level) begin
            if (SINGLE) begin
              state_nx = HIGH;
              evt_nx   = 1'b1;
            end else begin
              state_nx = ARM_HI;
              cnt_nx   = CW'(1);
            end
          end
        end
        ARM_HI: begin
          if (!sync_level) begin
            state_nx = LOW;
          end else if (cnt == CNT_LAST) begin
            state_nx = HIGH;
            evt_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!sync_level) begin
            if (SINGLE) begin
              state_nx = LOW;
            end else begin
              state_nx = ARM_LO;
              cnt_nx   = CW'(1);
            end
          end
        end
        ARM_LO: begin
          if (sync_level) begin
            state_nx = HIGH;
          end else if (cnt == CNT_LAST) begin
            state_nx = LOW;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: state_nx = LOW;
      endcase
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Turns manual/slow step sources into one-cycle step_en pulses; step_en 7 cycles after a manual
// rise (default debounce), 4 after a slow edge; ready low holds one pending step, further events set overrun.
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             manual,
  input  logic             slow,
  input  logic             select,
  input  logic             halt,
  input  logic             ready,
  output logic             step_en,
  output logic             pending,
  output logic             overrun,
  output logic [CNT_W-1:0] step_count,
  output logic             sel_sync
);

  logic [SYNC_DEPTH-1:0] slow_sq, sel_sq;
  logic slow_s, sel_s, slow_prev, slow_evt, blank_q;
  logic man_evt, man_sync;
  logic sel_chg, evt, evt_ok, issue;

  assign slow_s  = slow_sq[SYNC_DEPTH-1];
  assign sel_s   = sel_sq[SYNC_DEPTH-1];
  assign sel_chg = (sel_s != sel_sync);

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .din        (manual),
    .force_en   (sel_chg),
    .force_level(man_sync),
    .man_evt    (man_evt),
    .sync_level (man_sync)
  );

  // Events are blanked on the switch cycle and the one after it.
  assign evt    = ((sel_sync == SEL_SLOW) ? slow_evt : man_evt) & ~sel_chg & ~blank_q;
  assign evt_ok = evt & ~halt;
  // ~step_en keeps pulses at least two cycles apart when an event re-arms pending during an issue.
  assign issue  = pending & ready & ~step_en & ~sel_chg;

  always_ff @(posedge clk) begin
    if (reset) begin
      slow_sq    <= '0;
      sel_sq     <= '0;
      slow_prev  <= 1'b0;
      slow_evt   <= 1'b0;
      sel_sync   <= SEL_MANUAL;
      blank_q    <= 1'b0;
      step_en    <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      step_count <= '0;
    end else begin
      slow_sq   <= {slow_sq[SYNC_DEPTH-2:0], slow};
      sel_sq    <= {sel_sq[SYNC_DEPTH-2:0], select};
      slow_prev <= slow_s;
      slow_evt  <= slow_s & ~slow_prev & ~sel_chg;
      sel_sync  <= sel_s;
      blank_q   <= sel_chg;
      step_en   <= issue;
      if (issue)
        step_count <= step_count + CNT_W'(1);
      if (sel_chg)
        pending <= 1'b0;
      else if (evt_ok)
        pending <= 1'b1;
      else if (issue)
        pending <= 1'b0;
      if (evt_ok && pending && !issue)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: stimulus queues expected step_en cycle/count, a monitor pops on each pulse.
module tb_clk_step_ctrl;

  logic       clk = 1'b0;
  logic       reset, manual, slow, select, halt, ready;
  logic       step_en, pending, overrun, sel_sync;
  logic [3:0] step_count;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_cnt = 4'd0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  clk_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .manual    (manual),
    .slow      (slow),
    .select    (select),
    .halt      (halt),
    .ready     (ready),
    .step_en   (step_en),
    .pending   (pending),
    .overrun   (overrun),
    .step_count(step_count),
    .sel_sync  (sel_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge where the triggering input changes; delay counts from the next posedge.
  task automatic expect_step(input int delay);
    exp_t e;
    exp_cnt = exp_cnt + 4'd1;
    e.cyc   = cyc + 1 + delay;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (step_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step_en: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("step_cycle", cyc, e.cyc);
        check("step_count_at_step", {28'd0, step_count}, {28'd0, e.cnt});
      end
    end
  end

  initial begin
    reset = 1'b1; manual = 1'b0; slow = 1'b0; select = 1'b0; halt = 1'b0; ready = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_step_en", step_en, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_step_count", step_count, 0);
    check("rst_sel_sync", sel_sync, 0);
    tick(2);

    // Clean manual press, then release
    manual = 1'b1;
    expect_step(7);
    tick(10);
    manual = 1'b0;
    tick(12);
    check("man_count", step_count, 1);
    check("man_drained", exp_q.size(), 0);

    // Bouncy press: only the stable run counts
    for (int i = 0; i < 4; i++) begin
      manual = (i % 2 == 0);
      tick(1);
    end
    manual = 1'b1;
    expect_step(7);
    tick(10);
    manual = 1'b0;
    tick(12);
    check("bounce_count", step_count, 2);
    check("bounce_drained", exp_q.size(), 0);

    // Slow source, 5 rising edges, period 50
    select = 1'b1;
    tick(6);
    check("sel_slow", sel_sync, 1);
    for (int i = 0; i < 5; i++) begin
      slow = 1'b1;
      expect_step(4);
      tick(25);
      slow = 1'b0;
      tick(25);
    end
    check("slow_count", step_count, 7);
    check("slow_drained", exp_q.size(), 0);

    // Backpressure: two edges while ready is low
    ready = 1'b0;
    slow = 1'b1;
    tick(8);
    check("bp_pending", pending, 1);
    check("bp_no_overrun_yet", overrun, 0);
    slow = 1'b0;
    tick(10);
    slow = 1'b1;
    tick(8);
    check("bp_overrun", overrun, 1);
    check("bp_pending_held", pending, 1);
    slow = 1'b0;
    tick(14);
    expect_step(0);
    ready = 1'b1;
    tick(5);
    check("bp_pending_clear", pending, 0);
    check("bp_count", step_count, 8);

    // Source switch with a manual step waiting: pending is discarded
    select = 1'b0;
    tick(6);
    check("sel_manual", sel_sync, 0);
    ready = 1'b0;
    manual = 1'b1;
    tick(10);
    check("sw_pending_before", pending, 1);
    slow = 1'b1;
    tick(4);
    select = 1'b1;
    tick(5);
    check("sw_pending_cleared", pending, 0);
    check("sw_sel_sync", sel_sync, 1);
    ready = 1'b1;
    manual = 1'b0;
    tick(6);
    slow = 1'b0;
    tick(5);
    slow = 1'b1;
    expect_step(4);
    tick(10);
    slow = 1'b0;
    tick(5);
    check("sw_count", step_count, 9);
    check("overrun_sticky", overrun, 1);

    // Reset while a step is pending
    ready = 1'b0;
    slow = 1'b1;
    tick(6);
    check("rp_pending", pending, 1);
    reset = 1'b1;
    tick(1);
    check("rp_step_en", step_en, 0);
    check("rp_pending_zero", pending, 0);
    check("rp_overrun_zero", overrun, 0);
    check("rp_count_zero", step_count, 0);
    check("rp_sel_sync_zero", sel_sync, 0);
    tick(1);
    reset = 1'b0;
    slow = 1'b0;
    ready = 1'b1;
    exp_cnt = 4'd0;
    tick(6);
    check("rp_sel_resync", sel_sync, 1);
    check("rp_pending_after", pending, 0);

    // Counter wrap: 17 steps on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      slow = 1'b1;
      expect_step(4);
      tick(3);
      slow = 1'b0;
      tick(3);
    end
    tick(8);
    check("wrap_count", step_count, 1);

    // Halt discards events without flagging overrun
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slow = 1'b1;
      tick(5);
      slow = 1'b0;
      tick(5);
    end
    tick(5);
    check("halt_pending", pending, 0);
    check("halt_overrun", overrun, 0);
    check("halt_count", step_count, 1);
    halt = 1'b0;
    tick(5);

    check("all_steps_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Receiving end of the clock source selection path. Instead of driving logic with a derived `clk_out`, this block samples the manual step button and the slow tick inside the single system clock domain. It debounces the button, edge-detects the selected source, and issues exactly one-cycle `step_en` pulses to the CPU core under a ready handshake. It sits between the front-panel inputs and the core's clock-enable, and also counts issued steps.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronized samples needed to accept a manual level change (≥1).
- `CNT_W`, 16: width of step counter.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `manual` in 1: asynchronous push-button level. Active high.
- `slow` in 1: asynchronous slow square wave.
- `select` in 1: asynchronous source select. 0 = manual, 1 = slow.
- `halt` in 1: synchronous. While high, new step events are discarded.
- `ready` in 1: synchronous. Core can accept a step.
- `step_en` out 1: one-cycle step pulse, registered.
- `pending` out 1: a step event is waiting for `ready`.
- `overrun` out 1: sticky. An event arrived while `pending` was already high.
- `step_count` out CNT_W: number of `step_en` pulses issued, wraps.
- `sel_sync` out 1: synchronized `select` currently in effect.

## Operation
- `manual`, `slow` and `select` each pass through a 2-FF synchronizer (reset to 0).
- Manual debouncer FSM, states LOW, ARM_HI, HIGH, ARM_LO:
  - LOW → ARM_HI when sync=1; counter loads 1.
  - ARM_HI: sync=1 increments the counter. Reaching DEBOUNCE_CYCLES → HIGH and raises a one-cycle `man_evt`. sync=0 → LOW.
  - HIGH → ARM_LO when sync=0.
  - ARM_LO: sync=0 for DEBOUNCE_CYCLES → LOW with no event. sync=1 → HIGH.
- Slow path: rising edge of synchronized `slow` (prev=0, cur=1) raises a one-cycle `slow_evt`. No debounce.
- `evt = sel_sync ? slow_evt : man_evt`.
- Select change (synchronized value differs from `sel_sync`):
  - `sel_sync` updates.
  - `pending` clears.
  - The slow edge register reloads with the current level.
  - Debouncer jumps to LOW or HIGH matching the current sync level with no event.
  - `evt` is blanked that cycle and the next.
- Event acceptance:
  - `evt & ~halt & ~pending` sets `pending`.
  - `evt & ~halt & pending` sets `overrun`. The event is dropped.
  - `evt & halt`: event dropped, no flag.
- Issue: when `pending & ready`, `step_en`=1 next cycle, `pending` clears that same edge, and `step_count` increments that same edge (modulo 2^CNT_W; all-ones wraps to 0).
- Simultaneous issue and new event in one cycle: the issue completes and the new event sets `pending` again. Never overrun.
- `overrun` clears only on `reset`.

## Timing
- Reset values: `step_en`=0, `pending`=0, `overrun`=0, `step_count`=0, `sel_sync`=0, debouncer LOW.
- `reset` asserted mid-operation overrides everything on the next edge. Any pending step is lost.
- Manual latency, with `ready`=1: pin rise at edge t, then `man_evt` at t+1+DEBOUNCE_CYCLES, `pending` at t+2+DEBOUNCE_CYCLES, `step_en` at t+3+DEBOUNCE_CYCLES. Default is 7 cycles.
- Slow latency, with `ready`=1: `slow_evt` at t+2, `step_en` at t+4.
- `step_en` is never high on two consecutive cycles. Minimum spacing is 2 cycles.
- `ready` low holds `pending` indefinitely. `step_en` follows 1 cycle after `ready` rises.

## Structure
- Shared package `clk_step_pkg`:
  - debouncer state enum (LOW, ARM_HI, HIGH, ARM_LO);
  - `SEL_MANUAL`=0 and `SEL_SLOW`=1 constants;
  - synchronizer depth constant 2.
- One sub-module, `btn_debounce`: synchronizer, FSM and counter, outputting `man_evt` and a level. It takes a `force_level`/`force_en` input for select-change realignment.
- Slow edge detect, select handling, handshake and counter stay in the top level.

## Test plan
- Manual press, held for 10 cycles with `select`=0 and `ready`=1: one `step_en` at 7 cycles after the rise; `step_count`=1. Release produces no pulse.
- Bouncy press (1,0,1,0 per cycle, then stable 1 for 10 cycles): exactly one `step_en`, timed from the start of the stable run.
- `select`=1, slow period 50 cycles, 5 rising edges: 5 `step_en` pulses, each 4 cycles after its edge; `step_count`=5.
- `ready`=0 for 40 cycles across two slow edges: `pending`=1 after the first edge, `overrun`=1 after the second. On `ready`=1, one `step_en`; `step_count`=1.
- Toggle `select` 0→1 while `slow`=1 and manual is held high: no `step_en` and `pending` cleared. The next slow rising edge gives 1 pulse.
- With `CNT_W`=4, 17 steps give `step_count`=1. `reset` asserted while `pending`=1 gives all outputs 0 on the next edge and no `step_en`. With `halt`=1, 3 slow edges produce no pulses and no overrun.
